// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and producer side of the IF/ID latch.
//
// Owns the PC, requests instructions from the icache, and drives the IF/ID
// latch data (imemaddr, instr, next_addr) and controls (fd_enable, fd_flush).
// Every cycle with fd_enable=1 presents either a real instruction (fd_flush=0,
// data valid) or a flush, so the latch never captures stale data.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, imemload       icache hit and instruction word
//   imemREN, imemaddr    icache read enable and fetch address
//   instr, next_addr     IF/ID latch data inputs (instruction, pc+4)
//   enable               pipeline-advance permission from the hazard unit
//   redirect, redirect_pc  downstream taken branch/jump and its target
//   halt                 downstream committed halt
//   fd_enable, fd_flush  IF/ID latch enable and flush
//   halted               sticky: fetch stopped until reset
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer that
// holds an instruction returned during a stall, so the icache is not
// re-requested while the pipeline is stalled.

module fetch_unit #(
    parameter int unsigned          ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]    PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [31:0]       imemload,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] next_addr,
    input  logic              enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fd_enable,
    output logic              fd_flush,
    output logic              halted
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StFlushing = 2'd1,
        StHalted   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    // Flush owed to the latch: halt was accepted while the pipeline was stalled.
    logic              pend_q, pend_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redir_tgt;

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imemaddr  = pc_q;
    assign next_addr = pc_plus4;
    assign halted    = (state_q == StHalted);

`ifdef FETCH_SKID_EN
    logic [31:0] skid_q, skid_d;
    logic        skid_valid_q, skid_valid_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        imemREN   = 1'b1;
        fd_enable = 1'b0;
        fd_flush  = 1'b0;
        instr     = ihit ? imemload : 32'h0;
`ifdef FETCH_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
`endif

        case (state_q)
            StRun: begin
`ifdef FETCH_SKID_EN
                if (skid_valid_q) begin
                    instr = skid_q;
                end
`endif
                if (halt) begin
                    state_d   = StHalted;
                    fd_enable = enable;
                    fd_flush  = 1'b1;
                    pend_d    = ~enable;
`ifdef FETCH_SKID_EN
                    skid_valid_d = 1'b0;
`endif
                end else if (redirect) begin
                    // Old-pc instruction is dropped: flush rather than latch it.
                    pc_d      = redir_tgt;
                    fd_enable = enable;
                    fd_flush  = 1'b1;
                    if (!enable) begin
                        state_d = StFlushing;
                    end
`ifdef FETCH_SKID_EN
                    skid_valid_d = 1'b0;
                end else if (skid_valid_q) begin
                    imemREN = 1'b0;
                    if (enable) begin
                        fd_enable    = 1'b1;
                        pc_d         = pc_plus4;
                        skid_valid_d = 1'b0;
                    end
`endif
                end else if (enable) begin
                    fd_enable = 1'b1;
                    if (ihit) begin
                        pc_d = pc_plus4;
                    end else begin
                        fd_flush = 1'b1;  // bubble: no valid instruction this cycle
                    end
`ifdef FETCH_SKID_EN
                end else if (ihit) begin
                    skid_d       = imemload;
                    skid_valid_d = 1'b1;
`endif
                end
            end

            StFlushing: begin
                // pc already holds the target; push one flush into the latch.
                fd_flush  = 1'b1;
                fd_enable = enable;
                if (halt) begin
                    state_d = StHalted;
                    pend_d  = ~enable;
                end else begin
                    if (redirect) begin
                        pc_d = redir_tgt;
                    end
                    if (enable) begin
                        state_d = StRun;
                    end
                end
            end

            StHalted: begin
                imemREN  = 1'b0;
                fd_flush = 1'b1;
                if (pend_q && enable) begin
                    fd_enable = 1'b1;
                    pend_d    = 1'b0;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StRun;
            pc_q    <= PC_INIT;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_q       <= 32'h0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven bench for fetch_unit with a scoreboard queue.
// Each vector drives inputs after a rising edge; the expected outputs are
// queued at drive time and popped/compared at the following falling edge.

module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic [31:0] next_addr;
    logic        enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fd_enable;
    logic        fd_flush;
    logic        halted;

    fetch_unit #(
        .ADDR_W  (32),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .instr       (instr),
        .next_addr   (next_addr),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fd_enable   (fd_enable),
        .fd_flush    (fd_flush),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        halt;
        logic        redirect;
        logic [31:0] rpc;
        logic        en;
        logic        hit;
        logic [31:0] load;
        logic [31:0] e_addr;
        logic [31:0] e_next;
        logic [31:0] e_instr;
        logic        e_ren;
        logic        e_fde;
        logic        e_fdf;
        logic        e_hltd;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] next;
        logic [31:0] instr;
        logic        ren;
        logic        fde;
        logic        fdf;
        logic        hltd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;

    function automatic vec_t mk(logic h, logic r, logic [31:0] rpc, logic en, logic hit,
                                logic [31:0] load, logic [31:0] a, logic [31:0] n,
                                logic [31:0] i, logic ren, logic fde, logic fdf,
                                logic hl);
        vec_t v;
        v.halt = h; v.redirect = r; v.rpc = rpc; v.en = en; v.hit = hit; v.load = load;
        v.e_addr = a; v.e_next = n; v.e_instr = i; v.e_ren = ren; v.e_fde = fde;
        v.e_fdf = fdf; v.e_hltd = hl;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge, check at the falling edge,
    // then advance through the next rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        halt        = v.halt;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        enable      = v.en;
        ihit        = v.hit;
        imemload    = v.load;
        e.id = vec_id; e.addr = v.e_addr; e.next = v.e_next; e.instr = v.e_instr;
        e.ren = v.e_ren; e.fde = v.e_fde; e.fdf = v.e_fdf; e.hltd = v.e_hltd;
        sb.push_back(e);
        vec_id++;
        @(negedge CLK);
        got = sb.pop_front();
        chk("imemaddr",  got.id, imemaddr,          got.addr);
        chk("next_addr", got.id, next_addr,         got.next);
        chk("instr",     got.id, instr,             got.instr);
        chk("imemREN",   got.id, {31'h0, imemREN},   {31'h0, got.ren});
        chk("fd_enable", got.id, {31'h0, fd_enable}, {31'h0, got.fde});
        chk("fd_flush",  got.id, {31'h0, fd_flush},  {31'h0, got.fdf});
        chk("halted",    got.id, {31'h0, halted},    {31'h0, got.hltd});
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    vec_t        tbl[20];
    logic [31:0] pcx;

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; enable = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        //              h  r  rpc           en hit load          addr          next          instr         ren fde fdf hl
        tbl[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h4,        32'h0,        1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,        1, 1, 32'hA000_0000, 32'h0,       32'h4,        32'hA000_0000, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 1, 32'hA000_0001, 32'h4,       32'h8,        32'hA000_0001, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,        1, 1, 32'hA000_0002, 32'h8,       32'hC,        32'hA000_0002, 1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 32'h10,       1, 1, 32'hDEAD_0001, 32'hC,       32'h10,       32'hDEAD_0001, 1, 1, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 0, 32'hDEAD_0002, 32'h10,      32'h14,       32'h0,        1, 1, 1, 0);
        tbl[6]  = mk(0, 0, 32'h0,        1, 0, 32'hDEAD_0003, 32'h10,      32'h14,       32'h0,        1, 1, 1, 0);
        tbl[7]  = mk(0, 0, 32'h0,        1, 1, 32'hB000_0010, 32'h10,      32'h14,       32'hB000_0010, 1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 32'h20,       1, 0, 32'h0,        32'h14,       32'h18,       32'h0,        1, 1, 1, 0);
        tbl[9]  = mk(0, 1, 32'h103,      0, 1, 32'hC000_0000, 32'h20,      32'h24,       32'hC000_0000, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h100,      32'h104,      32'h0,        1, 0, 1, 0);
        tbl[11] = mk(0, 0, 32'h0,        1, 1, 32'hD000_0000, 32'h100,     32'h104,      32'hD000_0000, 1, 1, 1, 0);
        tbl[12] = mk(0, 0, 32'h0,        1, 1, 32'hE000_0000, 32'h100,     32'h104,      32'hE000_0000, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h104,      32'h108,      32'h0,        1, 0, 0, 0);
        tbl[14] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,       32'h104,      32'h108,      32'h0,        1, 1, 1, 0);
        tbl[15] = mk(0, 0, 32'h0,        1, 1, 32'hF000_0000, 32'hFFFF_FFFC, 32'h0,     32'hF000_0000, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h4,        32'h0,        1, 1, 1, 0);
        tbl[17] = mk(1, 1, 32'h200,      1, 1, 32'h1234_5678, 32'h0,       32'h4,        32'h1234_5678, 1, 1, 1, 0);
        tbl[18] = mk(0, 1, 32'h300,      1, 1, 32'h8765_4321, 32'h0,       32'h4,        32'h8765_4321, 0, 0, 1, 1);
        tbl[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h4,        32'h0,        0, 0, 1, 1);

        #12;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i]);
        end

        // Reset out of HALTED restores PC_INIT and running fetch.
        pulse_reset();
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h0, 1, 0, 0, 0));

        // Stall with ihit=1 at pc=0x40.
        apply(mk(0, 1, 32'h40, 1, 0, 32'h0, 32'h0, 32'h4, 32'h0, 1, 1, 1, 0));
        apply(mk(0, 0, 32'h0, 0, 1, 32'h5555_0001, 32'h40, 32'h44, 32'h5555_0001, 1, 0, 0, 0));
`ifdef FETCH_SKID_EN
        apply(mk(0, 0, 32'h0, 0, 1, 32'h5555_0002, 32'h40, 32'h44, 32'h5555_0001, 0, 0, 0, 0));
        apply(mk(0, 0, 32'h0, 0, 1, 32'h5555_0003, 32'h40, 32'h44, 32'h5555_0001, 0, 0, 0, 0));
        apply(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'h40, 32'h44, 32'h5555_0001, 0, 1, 0, 0));
        pcx = 32'h44;
`else
        apply(mk(0, 0, 32'h0, 0, 1, 32'h5555_0002, 32'h40, 32'h44, 32'h5555_0002, 1, 0, 0, 0));
        apply(mk(0, 0, 32'h0, 0, 1, 32'h5555_0003, 32'h40, 32'h44, 32'h5555_0003, 1, 0, 0, 0));
        apply(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'h40, 32'h44, 32'h0,         1, 1, 1, 0));
        pcx = 32'h40;
`endif

        // Halt while stalled: flush owed, issued on first enabled cycle in HALTED.
        apply(mk(1, 0, 32'h0,   0, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 1, 0, 1, 0));
        apply(mk(0, 0, 32'h0,   0, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 0, 0, 1, 1));
        apply(mk(0, 0, 32'h0,   1, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 0, 1, 1, 1));
        apply(mk(0, 0, 32'h0,   1, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 0, 0, 1, 1));
        apply(mk(1, 1, 32'h500, 1, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 0, 0, 1, 1));
        apply(mk(0, 0, 32'h0,   1, 0, 32'h0, pcx, pcx + 32'd4, 32'h0, 0, 0, 1, 1));

        // Reset in FLUSHING discards the pending redirect.
        pulse_reset();
        apply(mk(0, 1, 32'h80, 0, 0, 32'h0, 32'h0,  32'h4,  32'h0, 1, 0, 1, 0));
        pulse_reset();
        apply(mk(0, 0, 32'h0,  1, 0, 32'h0, 32'h0,  32'h4,  32'h0, 1, 1, 1, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
